// File: rtl/inst_fetch_if.sv
// Fetch-unit bundle: instruction ROM read port, redirect input from execute,
// and the decode-side valid/ready channel with status outputs.
interface inst_fetch_if;
  logic        irom_req;
  logic [31:0] irom_addr;
  logic        irom_ack;
  logic [31:0] irom_rdata;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  modport master (
    output irom_req, irom_addr, inst_valid, inst_out, pc_out, pc4_out,
           fetch_err, fetch_cnt,
    input  irom_ack, irom_rdata, redir_valid, redir_target, inst_ready
  );

  modport slave (
    input  irom_req, irom_addr, inst_valid, inst_out, pc_out, pc4_out,
           fetch_err, fetch_cnt,
    output irom_ack, irom_rdata, redir_valid, redir_target, inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch unit: one ROM request at a time, one
// buffered instruction toward decode, redirects with drain of in-flight reads.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        redir_ok_s;
  logic        redir_bad_s;

  assign redir_ok_s  = bus.redir_valid && (bus.redir_target[1:0] == 2'b00);
  assign redir_bad_s = bus.redir_valid && (bus.redir_target[1:0] != 2'b00);

  // Next-state and datapath update; misaligned redirects dominate everything.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redir_bad_s) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (redir_ok_s) begin
          if (bus.irom_ack) begin
            pc_d = bus.redir_target;
          end else begin
            pend_d  = bus.redir_target;
            state_d = ST_DRAIN;
          end
        end else if (bus.irom_ack) begin
          inst_d   = bus.irom_rdata;
          pc_out_d = pc_q;
          state_d  = ST_HOLD;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (redir_bad_s) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (redir_ok_s) begin
          pc_d    = bus.redir_target;
          state_d = ST_REQ;
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + 32'd4;
          cnt_d   = cnt_q + 32'd1;
          state_d = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        // The read in flight belongs to the old path; its data is dropped.
        if (redir_bad_s) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (redir_ok_s) begin
          if (bus.irom_ack) begin
            pc_d    = bus.redir_target;
            state_d = ST_REQ;
          end else begin
            pend_d = bus.redir_target;
          end
        end else if (bus.irom_ack) begin
          pc_d    = pend_q;
          state_d = ST_REQ;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end
    endcase
    req_d   = (state_d == ST_REQ) || (state_d == ST_DRAIN);
    valid_d = (state_d == ST_HOLD);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      inst_q   <= 32'h0000_0000;
      pend_q   <= 32'h0000_0000;
      cnt_q    <= 32'h0000_0000;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.irom_req   = req_q;
  assign bus.irom_addr  = pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst_out   = inst_q;
  assign bus.pc_out     = pc_out_q;
  assign bus.pc4_out    = pc_out_q + 32'd4;
  assign bus.fetch_err  = err_q;
  assign bus.fetch_cnt  = cnt_q;

endmodule
